byte_striping_tx: RTL and testbench

- Transmit-side stage directly upstream of the 4-lane parallel-to-serial transmitter.
- Accepts a byte stream with a valid qualifier and distributes bytes round-robin across 1, 2 or 4 active lanes.
- Emits one assembled 32-bit lane word with a one-cycle OUT_VALID pulse per completed group.
- Runs in the 250 KHz word domain; its lane outputs and OUT_VALID feed the transmitter's IN_LANE0..3 and IN_VALID_TX.

---
 rtl/byte_striping_tx_if.sv | 25 ++
 rtl/byte_striping_tx.sv | 98 +++++++++
 tb/tb_byte_striping_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/byte_striping_tx_if.sv
// Byte-in / lane-word-out bundle between the byte source, the striper and the
// 4-lane serialiser. Signal names match the serialiser-facing pin names.
interface byte_striping_tx_if;
  logic       IN_ENB;
  logic [2:0] IN_CTR;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_FLUSH;
  logic [7:0] OUT_LANE0;
  logic [7:0] OUT_LANE1;
  logic [7:0] OUT_LANE2;
  logic [7:0] OUT_LANE3;
  logic       OUT_VALID;
  logic       OUT_BUSY;

  modport master (
    output IN_ENB, IN_CTR, IN_DATA, IN_VALID, IN_FLUSH,
    input  OUT_LANE0, OUT_LANE1, OUT_LANE2, OUT_LANE3, OUT_VALID, OUT_BUSY
  );

  modport slave (
    input  IN_ENB, IN_CTR, IN_DATA, IN_VALID, IN_FLUSH,
    output OUT_LANE0, OUT_LANE1, OUT_LANE2, OUT_LANE3, OUT_VALID, OUT_BUSY
  );
endinterface

// File: rtl/byte_striping_tx.sv
// Round-robin byte striper: packs 1/2/4 bytes into a 4-lane word and pulses
// OUT_VALID for one cycle per completed (or flushed) group.
module bst_lane #(
  parameter int              LANE     = 0,
  parameter int              VEC_W    = 8,
  parameter logic [VEC_W-1:0] IDLE_SYM = 8'hBC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             emit,
  input  logic [2:0]       n_eff,
  input  logic [2:0]       cnt_a,
  input  logic [VEC_W-1:0] slot,
  output logic [VEC_W-1:0] lane_q
);
  localparam logic [2:0] IDX = 3'(LANE);

  // Lanes beyond the group width are zero; unfilled slots of a flushed group pad with IDLE_SYM.
  always_ff @(posedge clk) begin
    if (rst)               lane_q <= IDLE_SYM;
    else if (!emit)        lane_q <= IDLE_SYM;
    else if (IDX >= n_eff) lane_q <= '0;
    else if (IDX >= cnt_a) lane_q <= IDLE_SYM;
    else                   lane_q <= slot;
  end
endmodule

module byte_striping_tx #(
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic                IN_CLK_250KHz,
  input  logic                IN_RESET,
  byte_striping_tx_if.slave   bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [2:0] cnt_q, n_q, ctr_n, n_eff, cnt_a;
  logic       acc, complete, flush, emit;
  logic       valid_q, busy_q;
  logic [NUM_LANES-1:0][VEC_W-1:0] asm_q, asm_a, lane_q;

  always_comb begin
    case (bus.IN_CTR)
      3'b000:  ctr_n = 3'd1;
      3'b001:  ctr_n = 3'd2;
      default: ctr_n = 3'd4;
    endcase
  end

  // Mode is only taken from IN_CTR on the first byte of a group.
  assign acc      = bus.IN_ENB & bus.IN_VALID;
  assign n_eff    = (cnt_q == 3'd0) ? ctr_n : n_q;
  assign cnt_a    = cnt_q + {2'b00, acc};
  assign complete = acc && (cnt_a == n_eff);
  assign flush    = bus.IN_ENB && bus.IN_FLUSH && (cnt_a != 3'd0) && !complete;
  assign emit     = complete | flush;

  always_comb begin
    asm_a = asm_q;
    if (acc) asm_a[cnt_q[1:0]] = bus.IN_DATA;
  end

  always_ff @(posedge IN_CLK_250KHz) begin
    if (IN_RESET) begin
      cnt_q   <= '0;
      n_q     <= 3'd4;
      asm_q   <= {NUM_LANES{IDLE_SYM}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= emit ? 3'd0 : cnt_a;
      asm_q   <= asm_a;
      valid_q <= emit;
      busy_q  <= !emit && (cnt_a != 3'd0);
      if (acc && cnt_q == 3'd0) n_q <= ctr_n;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    bst_lane #(.LANE(k), .VEC_W(VEC_W), .IDLE_SYM(IDLE_SYM)) u_lane (
      .clk    (IN_CLK_250KHz),
      .rst    (IN_RESET),
      .emit   (emit),
      .n_eff  (n_eff),
      .cnt_a  (cnt_a),
      .slot   (asm_a[k]),
      .lane_q (lane_q[k])
    );
  end

  assign bus.OUT_LANE0 = lane_q[0];
  assign bus.OUT_LANE1 = lane_q[1];
  assign bus.OUT_LANE2 = lane_q[2];
  assign bus.OUT_LANE3 = lane_q[3];
  assign bus.OUT_VALID = valid_q;
  assign bus.OUT_BUSY  = busy_q;
endmodule

// File: tb/tb_byte_striping_tx.sv
// Scoreboard bench for byte_striping_tx: a byte-queue model predicts each
// cycle's {valid, busy, lanes}; a monitor pops and compares after every edge.
module tb_byte_striping_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_striping_tx_if bus();

  byte_striping_tx dut (
    .IN_CLK_250KHz (clk),
    .IN_RESET      (rst),
    .bus           (bus)
  );

  typedef struct packed {
    logic        v;
    logic        b;
    logic [31:0] w;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] grp[$];
  int         n_m = 4;
  int         n_run = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dec(input logic [2:0] c);
    if (c == 3'b000) return 1;
    if (c == 3'b001) return 2;
    return 4;
  endfunction

  // Drive one cycle of inputs and push the model's prediction for the next edge.
  task automatic drv(input bit r, input bit e, input logic [2:0] c,
                     input logic [7:0] d, input bit v, input bit f);
    exp_t x;
    bit   em;
    @(negedge clk);
    rst = r; bus.IN_ENB = e; bus.IN_CTR = c; bus.IN_DATA = d;
    bus.IN_VALID = v; bus.IN_FLUSH = f;
    x.v = 1'b0; x.w = {4{8'hBC}}; em = 1'b0;
    if (r) begin
      grp.delete();
      n_m = 4;
    end else if (e) begin
      if (v) begin
        if (grp.size() == 0) n_m = dec(c);
        grp.push_back(d);
        if (grp.size() == n_m) em = 1'b1;
      end
      if (!em && f && grp.size() > 0) em = 1'b1;
      if (em) begin
        x.v = 1'b1;
        for (int k = 0; k < 4; k++)
          x.w[8*k +: 8] = (k >= n_m) ? 8'h00 : (k < grp.size()) ? grp[k] : 8'hBC;
        grp.delete();
      end
    end
    x.b = (grp.size() != 0);
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 1, 3'b010, 8'h00, 0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("valid", {31'd0, bus.OUT_VALID}, {31'd0, x.v});
        chk("busy",  {31'd0, bus.OUT_BUSY},  {31'd0, x.b});
        chk("lanes", {bus.OUT_LANE3, bus.OUT_LANE2, bus.OUT_LANE1, bus.OUT_LANE0}, x.w);
      end
    end
  end

  initial begin
    bus.IN_ENB = 0; bus.IN_CTR = 3'b010; bus.IN_DATA = 0; bus.IN_VALID = 0; bus.IN_FLUSH = 0;
    drv(1, 0, 3'b010, 8'h00, 0, 0);
    drv(1, 1, 3'b010, 8'h00, 1, 1);
    idle(1);

    // 4-lane group
    drv(0, 1, 3'b010, 8'h11, 1, 0);
    drv(0, 1, 3'b010, 8'h22, 1, 0);
    drv(0, 1, 3'b010, 8'h33, 1, 0);
    drv(0, 1, 3'b010, 8'h44, 1, 0);
    idle(2);

    // 2-lane continuous stream
    for (int i = 0; i < 6; i++) drv(0, 1, 3'b001, 8'(8'hA0 + i), 1, 0);
    idle(2);

    // flush of a partial group, then flush while empty
    drv(0, 1, 3'b010, 8'h01, 1, 0);
    drv(0, 1, 3'b010, 8'h02, 1, 0);
    drv(0, 1, 3'b010, 8'h00, 0, 1);
    drv(0, 1, 3'b010, 8'h00, 0, 1);
    idle(1);

    // mode change mid-group applies to the next group
    drv(0, 1, 3'b010, 8'h50, 1, 0);
    drv(0, 1, 3'b000, 8'h51, 1, 0);
    drv(0, 1, 3'b000, 8'h52, 1, 0);
    drv(0, 1, 3'b000, 8'h53, 1, 0);
    drv(0, 1, 3'b000, 8'h60, 1, 0);
    drv(0, 1, 3'b000, 8'h61, 1, 0);
    idle(1);

    // enable gating mid-group
    drv(0, 1, 3'b010, 8'h70, 1, 0);
    drv(0, 1, 3'b010, 8'h71, 1, 0);
    drv(0, 0, 3'b000, 8'hFF, 1, 0);
    drv(0, 0, 3'b000, 8'hFF, 1, 1);
    drv(0, 0, 3'b000, 8'hFF, 1, 0);
    drv(0, 1, 3'b000, 8'h72, 1, 0);
    drv(0, 1, 3'b000, 8'h73, 1, 0);
    idle(1);

    // reset discards a partial group
    drv(0, 1, 3'b010, 8'h80, 1, 0);
    drv(0, 1, 3'b010, 8'h81, 1, 0);
    drv(0, 1, 3'b010, 8'h82, 1, 0);
    drv(1, 1, 3'b010, 8'h83, 1, 1);
    for (int i = 0; i < 4; i++) drv(0, 1, 3'b010, 8'(8'h90 + i), 1, 0);
    idle(1);

    // flush together with a byte: completing and non-completing, plus reserved mode code
    drv(0, 1, 3'b001, 8'hB0, 1, 0);
    drv(0, 1, 3'b001, 8'hB1, 1, 1);
    drv(0, 1, 3'b111, 8'hC0, 1, 0);
    drv(0, 1, 3'b111, 8'hC1, 1, 1);
    drv(0, 1, 3'b001, 8'hD0, 1, 1);
    drv(0, 1, 3'b000, 8'hE0, 1, 1);
    idle(1);

    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
          8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    idle(2);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
